// File: rtl/decoder_pkg.sv
// Shared types and helpers for the registered N-output decoder family.
package decoder_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    function automatic int unsigned out_count(input int unsigned sel_w);
        return 32'd1 << sel_w;
    endfunction

endpackage

// File: rtl/decoder_n.sv
// Combinational SEL_W-to-2^SEL_W enabled decoder: one-hot when en, else all-zero.
module decoder_n
    import decoder_pkg::*;
#(
    parameter int SEL_W = 5
) (
    input  logic                          en,
    input  logic [SEL_W-1:0]              sel,
    output logic [out_count(SEL_W)-1:0]   dec
);

    always_comb begin
        dec = '0;
        if (en) begin
            dec[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/decoder_n_seq.sv
// Registered one-hot decoder with a sweep mode that walks every output once,
// used to initialise the register-file write enables after reset.
module decoder_n_seq
    import decoder_pkg::*;
#(
    parameter int SEL_W    = 5,
    parameter int MASK_TOP = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic [SEL_W-1:0]              sel,
    input  logic                          sweep_start,
    output logic [out_count(SEL_W)-1:0]   out,
    output logic                          sweep_busy,
    output logic                          sweep_done
);

    localparam int N  = out_count(SEL_W);
    localparam int CW = SEL_W + 1;

    state_t          state, state_next;
    logic [CW-1:0]   counter, counter_next;
    logic            busy_next, done_next;
    logic            dec_en;
    logic [SEL_W-1:0] dec_sel;
    logic [N-1:0]    dec, out_next;

    // Input mux: direct en/sel in IDLE, forced enable with the counter while sweeping.
    always_comb begin
        state_next   = state;
        counter_next = '0;
        busy_next    = 1'b0;
        done_next    = 1'b0;
        dec_en       = en;
        dec_sel      = sel;
        case (state)
            IDLE: begin
                if (sweep_start) begin
                    state_next   = SWEEP;
                    counter_next = CW'(1);
                    busy_next    = 1'b1;
                    dec_en       = 1'b1;
                    dec_sel      = '0;
                end
            end
            SWEEP: begin
                if (counter == CW'(N)) begin
                    // Every output has been shown; fall straight back to direct decode.
                    state_next = IDLE;
                end else begin
                    counter_next = counter + CW'(1);
                    busy_next    = 1'b1;
                    done_next    = (counter == CW'(N - 1));
                    dec_en       = 1'b1;
                    dec_sel      = counter[SEL_W-1:0];
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    decoder_n #(.SEL_W(SEL_W)) u_decoder_n (
        .en  (dec_en),
        .sel (dec_sel),
        .dec (dec)
    );

    // The top output is the hard-wired zero register when masked.
    always_comb begin
        out_next = dec;
        if (MASK_TOP != 0) begin
            out_next[N-1] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            counter    <= '0;
            out        <= '0;
            sweep_busy <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            state      <= state_next;
            counter    <= counter_next;
            out        <= out_next;
            sweep_busy <= busy_next;
            sweep_done <= done_next;
        end
    end

endmodule

// File: tb/tb_decoder_n_seq.sv
// Bench for decoder_n_seq at SEL_W=3: one unmasked and one masked instance on shared inputs.
module tb_decoder_n_seq;

    localparam int SEL_W = 3;
    localparam int N     = 8;
    localparam int W     = 20;

    typedef struct {
        logic         en;
        logic [2:0]   sel;
        logic         start;
        logic [7:0]   exp0;
        logic [7:0]   exp1;
        logic         busy;
        logic         done;
    } vec_t;

    logic         clk;
    logic         reset;
    logic         en;
    logic [2:0]   sel;
    logic         sweep_start;
    logic [N-1:0] out0, out1;
    logic         busy0, done0, busy1, done1;

    logic [W-1:0] exp_q[$];
    int checks;
    int errors;
    vec_t vecs[$];

    decoder_n_seq #(.SEL_W(SEL_W), .MASK_TOP(0)) dut0 (
        .clk(clk), .reset(reset), .en(en), .sel(sel), .sweep_start(sweep_start),
        .out(out0), .sweep_busy(busy0), .sweep_done(done0)
    );

    decoder_n_seq #(.SEL_W(SEL_W), .MASK_TOP(1)) dut1 (
        .clk(clk), .reset(reset), .en(en), .sel(sel), .sweep_start(sweep_start),
        .out(out1), .sweep_busy(busy1), .sweep_done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] pack_exp(logic [7:0] e0, logic [7:0] e1, logic b, logic d);
        return {e0, e1, b, d, b, d};
    endfunction

    function automatic logic [W-1:0] pack_act();
        return {out0, out1, busy0, done0, busy1, done1};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got out0=%h out1=%h b0=%b d0=%b b1=%b d1=%b, expected out0=%h out1=%h busy=%b done=%b",
                     name, act[19:12], act[11:4], act[3], act[2], act[1], act[0],
                     exp[19:12], exp[11:4], exp[3], exp[2]);
        end
    endtask

    task automatic check_invariants(input string name);
        checks++;
        if (!$onehot0(out0) || !$onehot0(out1) || (done0 && !busy0) || (done1 && !busy1)) begin
            errors++;
            $display("FAIL %s invariant: out0=%h out1=%h b0=%b d0=%b b1=%b d1=%b, required one-hot/zero and done->busy",
                     name, out0, out1, busy0, done0, busy1, done1);
        end
    endtask

    // Drive one edge worth of inputs, queue the expectation, compare just after the edge.
    task automatic step(input string name, input logic e, input logic [2:0] s, input logic st,
                        input logic [7:0] e0, input logic [7:0] e1, input logic b, input logic d);
        logic [W-1:0] exp;
        @(negedge clk);
        en = e;
        sel = s;
        sweep_start = st;
        exp_q.push_back(pack_exp(e0, e1, b, d));
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        check(name, pack_act(), exp);
        check_invariants(name);
    endtask

    task automatic add(input logic e, input logic [2:0] s, input logic st,
                       input logic [7:0] e0, input logic [7:0] e1, input logic b, input logic d);
        vec_t v;
        v.en = e; v.sel = s; v.start = st; v.exp0 = e0; v.exp1 = e1; v.busy = b; v.done = d;
        vecs.push_back(v);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        en = 1'b0;
        sel = '0;
        sweep_start = 1'b0;

        // Direct decode on both instances; sel=7 is masked on the second one.
        add(1, 3'd3, 0, 8'h08, 8'h08, 0, 0);
        add(1, 3'd0, 0, 8'h01, 8'h01, 0, 0);
        add(1, 3'd7, 0, 8'h80, 8'h00, 0, 0);
        add(0, 3'd7, 0, 8'h00, 8'h00, 0, 0);
        add(1, 3'd5, 0, 8'h20, 8'h20, 0, 0);
        // Sweep with en/sel/sweep_start interference throughout.
        add(0, 3'd0, 1, 8'h01, 8'h01, 1, 0);
        for (int k = 1; k < N - 1; k++) begin
            add(1, 3'd5, 1, 8'(1 << k), 8'(1 << k), 1, 0);
        end
        add(1, 3'd5, 1, 8'h80, 8'h00, 1, 1);
        add(1, 3'd2, 0, 8'h04, 8'h04, 0, 0);
        add(0, 3'd0, 0, 8'h00, 8'h00, 0, 0);
        add(0, 3'd0, 0, 8'h00, 8'h00, 0, 0);
        // Start and direct enable on the same edge: the sweep takes precedence.
        add(1, 3'd4, 1, 8'h01, 8'h01, 1, 0);
        for (int k = 1; k < N - 1; k++) begin
            add(0, 3'd0, 0, 8'(1 << k), 8'(1 << k), 1, 0);
        end
        add(0, 3'd0, 0, 8'h80, 8'h00, 1, 1);
        add(0, 3'd0, 0, 8'h00, 8'h00, 0, 0);

        // Asynchronous reset asserted mid-cycle.
        #7;
        reset = 1'b0;
        #1;
        check("reset_immediate", pack_act(), pack_exp(8'h00, 8'h00, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", pack_act(), pack_exp(8'h00, 8'h00, 0, 0));
        @(negedge clk);
        reset = 1'b1;
        step("idle_after_reset", 0, 3'd0, 0, 8'h00, 8'h00, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i].en, vecs[i].sel, vecs[i].start,
                 vecs[i].exp0, vecs[i].exp1, vecs[i].busy, vecs[i].done);
        end

        // Reset in the middle of a sweep, then confirm a fresh sweep restarts at output 0.
        step("ms_start", 0, 3'd0, 1, 8'h01, 8'h01, 1, 0);
        step("ms_1", 0, 3'd0, 0, 8'h02, 8'h02, 1, 0);
        step("ms_2", 0, 3'd0, 0, 8'h04, 8'h04, 1, 0);
        step("ms_3", 0, 3'd0, 0, 8'h08, 8'h08, 1, 0);
        #3;
        reset = 1'b0;
        #1;
        check("ms_reset_immediate", pack_act(), pack_exp(8'h00, 8'h00, 0, 0));
        @(negedge clk);
        reset = 1'b1;
        step("ms_idle_1", 0, 3'd0, 0, 8'h00, 8'h00, 0, 0);
        step("ms_idle_2", 0, 3'd0, 0, 8'h00, 8'h00, 0, 0);
        step("ms_restart", 0, 3'd0, 1, 8'h01, 8'h01, 1, 0);
        step("ms_restart_1", 0, 3'd0, 0, 8'h02, 8'h02, 1, 0);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL exp_q_drained: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decoder_n_seq.md
Name: decoder_n_seq

Overview:
- Parametrised, registered successor to the 1:2 enabled decoder.
- Decodes an SEL_W-bit select into a 2^SEL_W one-hot output when enabled.
- Adds a sweep mode that asserts each output in turn, one per cycle. The sweep is used to clear or initialise the register file after reset.
- Sits in front of the register-file write-enable array in the pipelined CPU.

Parameters:
- SEL_W, 5, select width; output count N = 2^SEL_W (32 for the register file).
- MASK_TOP, 1, when 1 output N-1 is never asserted (hard-wired zero register XZR); when 0 all outputs are usable.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  direct-mode enable.
- sel  input  SEL_W  direct-mode select.
- sweep_start  input  1  single-cycle request to begin a sweep; sampled only in IDLE.
- out  output  2^SEL_W  registered one-hot (or all-zero) output.
- sweep_busy  output  1  high while a sweep is in progress.
- sweep_done  output  1  one-cycle pulse coincident with the final sweep output cycle.

Behaviour:
- Reset (reset=0, asynchronous): out=0, sweep_busy=0, sweep_done=0, counter=0, state=IDLE. Takes effect immediately, including mid-sweep; an interrupted sweep is abandoned, never resumed. Outputs stay 0 until the first rising edge after reset deasserts.
- States: IDLE, SWEEP.
- IDLE, sweep_start=0: each edge loads out = en ? onehot(sel) : 0. Latency is exactly 1 cycle.
- IDLE, sweep_start=1: sweep_start wins over en/sel. On that edge: out = onehot(0), counter=1, sweep_busy=1, state=SWEEP.
- SWEEP: each edge loads out = onehot(counter), then counter increments. en, sel and sweep_start are ignored; a repeated sweep_start is dropped, not queued.
- Final sweep output: when out=onehot(N-1) is loaded, sweep_done=1 for that cycle only.
- Sweep exit: on the next edge, state=IDLE, sweep_busy=0, sweep_done=0, counter=0, and out loads the direct decode of en/sel sampled at that edge. No bubble cycle.
- Sweep timing: sweep_start sampled at edge t gives sweep_busy high for exactly N cycles (t+1 .. t+N). Output k is asserted during cycle t+1+k.
- Counter: SEL_W+1 bits wide, so the terminal count is detected without wrap ambiguity. Counter is 0 whenever state is IDLE.
- MASK_TOP=1: bit N-1 of out is forced to 0 in both modes.
  - Direct: sel=N-1 with en=1 gives out=0.
  - Sweep: still takes N cycles and still pulses sweep_done in the last cycle, but out=0 in that cycle.
- Invariants:
  - out is always one-hot or all-zero.
  - sweep_done implies sweep_busy.
  - No X on out after reset, given known inputs.

Decomposition:
- Shared package decoder_pkg: state typedef (IDLE, SWEEP) and a function computing output count from SEL_W.
- Sub-module decoder_n: purely combinational, parametrised SEL_W-to-2^SEL_W enabled decoder (generalised gate-level decoder). Instantiated once.
- decoder_n_seq adds:
  - an input mux between sel/en and counter/1;
  - the MASK_TOP gating;
  - the output register, counter and FSM.

Test Plan (SEL_W=3, N=8 unless noted):
- Reset then idle: reset=0 mid-cycle -> out=0x00, busy=0, done=0 immediately; after release with en=0 -> out stays 0x00.
- Direct decode, MASK_TOP=0: en=1 with sel=3, then 0, then 7 on consecutive edges -> out=0x08, 0x01, 0x80, each one cycle after its sample; then en=0 -> 0x00 next cycle.
- Full sweep, MASK_TOP=0: sweep_start=1 for one cycle at edge t -> out=0x01,0x02,...,0x80 over cycles t+1..t+8; busy high exactly 8 cycles; done high only at t+8; at t+9 out = direct decode of en=1, sel=2 (0x04).
- Sweep with MASK_TOP=1 and interference: during the sweep drive en=1, sel=5, sweep_start=1 repeatedly -> inputs ignored; outputs 0x01..0x40 then 0x00 at t+8 with done=1; no second sweep starts.
- Simultaneous start and en in IDLE: en=1, sel=4, sweep_start=1 at the same edge -> out=0x01 (sweep wins); 0x10 never appears during the sweep.
- Reset mid-sweep: reset=0 asynchronously at cycle t+4 -> out=0x00, busy=0 immediately; after release with en=0 -> out=0x00 and state IDLE; a new sweep_start restarts from 0x01.
